// File: rtl/alu_arb_pkg.sv
// alu_arb_pkg
//   Shared definitions for the ALU share arbiter: ALU operation codes,
//   FSM state encoding and requester index constants.
//   Used by alu_rr_arbiter and alu_share_arbiter.
//   Optional build macro (used by alu_rr_arbiter): ALU_ARB_FIXED_PRIO_EN.
package alu_arb_pkg;

    // ALU operation codes (4-bit encoding of the external ALU)
    localparam logic [3:0] OP_AND      = 4'd0;
    localparam logic [3:0] OP_OR       = 4'd1;
    localparam logic [3:0] OP_NOR      = 4'd2;
    localparam logic [3:0] OP_ADD      = 4'd3;
    localparam logic [3:0] OP_SUB      = 4'd4;
    localparam logic [3:0] OP_INC      = 4'd5;
    localparam logic [3:0] OP_MULTPLUS = 4'd6;
    localparam logic [3:0] OP_MOV      = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    localparam int NUM_REQ  = 2;
    localparam int REQ_MAIN = 0;
    localparam int REQ_AUX  = 1;

endpackage

// File: rtl/alu_rr_arbiter.sv
// alu_rr_arbiter
//   Two-input grant logic for the ALU share arbiter.
//   Default build: round robin. When both requesters are valid the one named
//   by the pointer wins; a lone valid requester always wins. The pointer
//   moves to the other requester when a response completes (upd).
//   ALU_ARB_FIXED_PRIO_EN defined: requester 0 always wins, no pointer.
// Ports
//   clk, reset     clock / async active-high reset
//   valid[1:0]     request valid per requester
//   upd            response handshake completed this cycle
//   upd_owner      requester whose response completed
//   grant[1:0]     one-hot winner (all zero when nothing valid)
import alu_arb_pkg::*;

module alu_rr_arbiter (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_REQ-1:0] valid,
    input  logic               upd,
    input  logic               upd_owner,
    output logic [NUM_REQ-1:0] grant
);

`ifdef ALU_ARB_FIXED_PRIO_EN

    logic unused_fixed;
    assign unused_fixed = ^{clk, reset, upd, upd_owner};

    always_comb begin
        grant = '0;
        if (valid[REQ_MAIN])
            grant[REQ_MAIN] = 1'b1;
        else if (valid[REQ_AUX])
            grant[REQ_AUX] = 1'b1;
    end

`else

    logic ptr_q;  // requester preferred on a tie

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            ptr_q <= 1'b0;
        else if (upd)
            ptr_q <= ~upd_owner;
    end

    always_comb begin
        grant = '0;
        if (&valid)
            grant[ptr_q] = 1'b1;
        else
            grant = valid;
    end

`endif

endmodule

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU between requester 0 (main datapath)
//   and requester 1 (auxiliary). IDLE -> EXEC -> RESP -> IDLE.
//   IDLE accepts one request, EXEC drives the ALU from latched operands
//   (1 cycle, 1+MULT_EXTRA_CYCLES for MULTPLUS), RESP holds the captured
//   result until the owner takes it.
//   Optional build macro: ALU_ARB_FIXED_PRIO_EN (fixed priority to requester 0).
// Ports
//   clk, reset                         clock / async active-high reset
//   reqN_valid/ready/op/a/b            request channel per requester
//   rspN_valid/ready/result/zero       response channel per requester
//   alu_operation/alu_a/alu_b          to ALU (registered)
//   alu_result/alu_zero                from ALU
//   busy                               FSM not in IDLE
import alu_arb_pkg::*;

module alu_share_arbiter #(
    parameter int DATA_WIDTH        = 32,
    parameter int OP_WIDTH          = 4,
    parameter int MULT_EXTRA_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [OP_WIDTH-1:0]   req0_op,
    input  logic [DATA_WIDTH-1:0] req0_a,
    input  logic [DATA_WIDTH-1:0] req0_b,
    output logic                  rsp0_valid,
    input  logic                  rsp0_ready,
    output logic [DATA_WIDTH-1:0] rsp0_result,
    output logic                  rsp0_zero,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [OP_WIDTH-1:0]   req1_op,
    input  logic [DATA_WIDTH-1:0] req1_a,
    input  logic [DATA_WIDTH-1:0] req1_b,
    output logic                  rsp1_valid,
    input  logic                  rsp1_ready,
    output logic [DATA_WIDTH-1:0] rsp1_result,
    output logic                  rsp1_zero,
    output logic [OP_WIDTH-1:0]   alu_operation,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    output logic                  busy
);

    arb_state_t            state_q, state_d;
    logic [OP_WIDTH-1:0]   op_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
    logic                  zero_q;
    logic                  own_q;
    logic [3:0]            cnt_q;   // EXEC cycles remaining after this one

    logic [NUM_REQ-1:0] req_valid, req_ready, rsp_valid, rsp_ready, grant;
    logic               accept, rsp_done, acc_sel;
    logic [OP_WIDTH-1:0]   sel_op;
    logic [DATA_WIDTH-1:0] sel_a, sel_b;

    assign req_valid = {req1_valid, req0_valid};
    assign rsp_ready = {rsp1_ready, rsp0_ready};

    alu_rr_arbiter u_arb (
        .clk       (clk),
        .reset     (reset),
        .valid     (req_valid),
        .upd       (rsp_done),
        .upd_owner (own_q),
        .grant     (grant)
    );

    // Next state and handshake outputs
    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        rsp_valid = '0;
        case (state_q)
            ST_IDLE: begin
                // Gated by reset so no ready leaks out while reset is held
                if (!reset)
                    req_ready = grant;
                if (|req_ready)
                    state_d = ST_EXEC;
            end
            ST_EXEC: begin
                if (cnt_q == 4'd0)
                    state_d = ST_RESP;
            end
            ST_RESP: begin
                rsp_valid[own_q] = 1'b1;
                if (rsp_ready[own_q])
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept   = |req_ready;
    assign rsp_done = |(rsp_valid & rsp_ready);
    assign acc_sel  = req_ready[REQ_AUX];
    assign sel_op   = acc_sel ? req1_op : req0_op;
    assign sel_a    = acc_sel ? req1_a  : req0_a;
    assign sel_b    = acc_sel ? req1_b  : req0_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_q <= ST_IDLE;
        else
            state_q <= state_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            op_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            own_q  <= 1'b0;
            cnt_q  <= '0;
            res_q  <= '0;
            zero_q <= 1'b0;
        end else begin
            if (accept) begin
                op_q  <= sel_op;
                a_q   <= sel_a;
                b_q   <= sel_b;
                own_q <= acc_sel;
                cnt_q <= (sel_op == OP_WIDTH'(OP_MULTPLUS)) ? 4'(MULT_EXTRA_CYCLES) : 4'd0;
            end
            if (state_q == ST_EXEC) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    res_q  <= alu_result;
                    zero_q <= alu_zero;
                end
            end
        end
    end

    // ALU sees only the latched operands, so it is quiet outside EXEC
    assign alu_operation = op_q;
    assign alu_a         = a_q;
    assign alu_b         = b_q;

    assign req0_ready  = req_ready[REQ_MAIN];
    assign req1_ready  = req_ready[REQ_AUX];
    assign rsp0_valid  = rsp_valid[REQ_MAIN];
    assign rsp1_valid  = rsp_valid[REQ_AUX];
    assign rsp0_result = res_q;
    assign rsp1_result = res_q;
    assign rsp0_zero   = zero_q;
    assign rsp1_zero   = zero_q;
    assign busy        = (state_q != ST_IDLE);

endmodule
